// File: rtl/actmem_bankset_scheduler_if.sv
// actmem_bankset_scheduler_if: read/write request bus and per-set SRAM control bus of the bank-set scheduler
// Signals: read_req_i/read_set_i/read_addr_i, write_req_i/write_set_i/write_addr_i (requests in),
// read_ready_o, set_read_en_o, set_write_en_o, set_addr_o, rvalid_o, rset_o, rw_collision_o (scheduler out).
// Modports: master (request source / SRAM consumer), slave (the scheduler).
interface actmem_bankset_scheduler_if #(
    parameter int NUMBANKS    = 24,
    parameter int NUMBANKSETS = 3,
    parameter int ADDRWIDTH   = 12
);
    localparam int BSW = NUMBANKSETS > 1 ? $clog2(NUMBANKSETS) : 1;
    logic [NUMBANKS-1:0]                       read_req_i;
    logic [BSW-1:0]                            read_set_i;
    logic [NUMBANKS*ADDRWIDTH-1:0]             read_addr_i;
    logic [NUMBANKS-1:0]                       write_req_i;
    logic [BSW-1:0]                            write_set_i;
    logic [NUMBANKS*ADDRWIDTH-1:0]             write_addr_i;
    logic                                      read_ready_o;
    logic [NUMBANKSETS*NUMBANKS-1:0]           set_read_en_o;
    logic [NUMBANKSETS*NUMBANKS-1:0]           set_write_en_o;
    logic [NUMBANKSETS*NUMBANKS*ADDRWIDTH-1:0] set_addr_o;
    logic [NUMBANKS-1:0]                       rvalid_o;
    logic [BSW-1:0]                            rset_o;
    logic [NUMBANKS-1:0]                       rw_collision_o;
    modport master (
        output read_req_i, read_set_i, read_addr_i, write_req_i, write_set_i, write_addr_i,
        input  read_ready_o, set_read_en_o, set_write_en_o, set_addr_o, rvalid_o, rset_o, rw_collision_o
    );
    modport slave (
        input  read_req_i, read_set_i, read_addr_i, write_req_i, write_set_i, write_addr_i,
        output read_ready_o, set_read_en_o, set_write_en_o, set_addr_o, rvalid_o, rset_o, rw_collision_o
    );
endinterface

// File: rtl/actmem_bankset_scheduler.sv
// actmem_bankset_scheduler: issues per-bank SRAM reads/writes across bank sets, write wins on collision
// Ports: clk_i (clock), rst_ni (async active-low reset), bus (actmem_bankset_scheduler_if.slave).
// Optional feature: define ACTMEM_READ_REPLAY_EN to replay collided reads; otherwise they are dropped.
module actmem_bankset_scheduler #(
    parameter int NUMBANKS     = 24,
    parameter int NUMBANKSETS  = 3,
    parameter int ADDRWIDTH    = 12,
    parameter int READ_LATENCY = 1
) (
    input logic clk_i,
    input logic rst_ni,
    actmem_bankset_scheduler_if.slave bus
);
    localparam int BSW = NUMBANKSETS > 1 ? $clog2(NUMBANKSETS) : 1;

    typedef enum logic {IDLE, REPLAY} state_t;

    state_t                        state_q, state_d;
    logic [NUMBANKS-1:0]           cap_mask_q, cap_mask_d;
    logic [NUMBANKS*ADDRWIDTH-1:0] cap_addr_q;
    logic [BSW-1:0]                cap_set_q;
    logic                          capture;
    logic                          rd_set_ok, wr_set_ok;
    logic [BSW-1:0]                rd_set;
    logic [NUMBANKS-1:0]           rd_mask, wr_mask, collision, issue;
    logic [NUMBANKS*ADDRWIDTH-1:0] rd_addr;
    logic [NUMBANKS-1:0]           pv_q [READ_LATENCY];
    logic [BSW-1:0]                ps_q [READ_LATENCY];
    logic [BSW-1:0]                rset_q;

    assign rd_set_ok = 32'(bus.read_set_i) < NUMBANKSETS;
    assign wr_set_ok = 32'(bus.write_set_i) < NUMBANKSETS;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // In REPLAY the captured request replaces the live read port.
    always_comb begin
        bus.read_ready_o = rst_ni && state_q == IDLE;
        rd_set  = state_q == REPLAY ? cap_set_q : bus.read_set_i;
        rd_addr = state_q == REPLAY ? cap_addr_q : bus.read_addr_i;
        rd_mask = !rst_ni ? '0 : state_q == REPLAY ? cap_mask_q : rd_set_ok ? bus.read_req_i : '0;
    end

    assign wr_mask   = rst_ni && wr_set_ok ? bus.write_req_i : '0;
    assign collision = rd_set == bus.write_set_i ? rd_mask & wr_mask : '0;
    assign issue     = rd_mask & ~collision;
    assign bus.rw_collision_o = collision;

    // Replay mask always becomes this cycle's collision set: empty means back to IDLE.
    always_comb begin
`ifdef ACTMEM_READ_REPLAY_EN
        state_d    = |collision ? REPLAY : IDLE;
        cap_mask_d = collision;
        capture    = state_q == IDLE && |collision;
`else
        state_d    = IDLE;
        cap_mask_d = '0;
        capture    = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_mask_q <= '0;
            cap_addr_q <= '0;
            cap_set_q  <= '0;
        end else begin
            cap_mask_q <= cap_mask_d;
            if (capture) begin
                cap_addr_q <= bus.read_addr_i;
                cap_set_q  <= bus.read_set_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= '0;
                ps_q[i] <= '0;
            end
            rset_q <= '0;
        end else begin
            pv_q[0] <= issue;
            ps_q[0] <= rd_set;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
            end
            rset_q <= bus.rset_o;
        end
    end

    assign bus.rvalid_o = pv_q[READ_LATENCY-1];
    // rset_o tracks the set of the data currently at the SRAM output and holds it otherwise.
    assign bus.rset_o   = |pv_q[READ_LATENCY-1] ? ps_q[READ_LATENCY-1] : rset_q;

    for (genvar s = 0; s < NUMBANKSETS; s++) begin : g_set
        for (genvar b = 0; b < NUMBANKS; b++) begin : g_bank
            logic wen, ren;
            assign wen = bus.write_set_i == BSW'(s) && wr_mask[b];
            assign ren = rd_set == BSW'(s) && issue[b];
            assign bus.set_write_en_o[s*NUMBANKS+b] = wen;
            assign bus.set_read_en_o[s*NUMBANKS+b]  = ren;
            assign bus.set_addr_o[(s*NUMBANKS+b)*ADDRWIDTH +: ADDRWIDTH] =
                wen ? bus.write_addr_i[b*ADDRWIDTH +: ADDRWIDTH] :
                ren ? rd_addr[b*ADDRWIDTH +: ADDRWIDTH] : '0;
        end
    end
endmodule

// File: tb/tb_actmem_bankset_scheduler.sv
// tb_actmem_bankset_scheduler: directed self-checking bench for actmem_bankset_scheduler
// Instances: u0 (defaults, READ_LATENCY=1) and u3 (READ_LATENCY=3); expectations follow ACTMEM_READ_REPLAY_EN.
module tb_actmem_bankset_scheduler;
`ifdef ACTMEM_READ_REPLAY_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int checks = 0;
    int passes = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    actmem_bankset_scheduler_if #(.NUMBANKS(24), .NUMBANKSETS(3), .ADDRWIDTH(12)) if0 ();
    actmem_bankset_scheduler_if #(.NUMBANKS(24), .NUMBANKSETS(3), .ADDRWIDTH(12)) if3 ();

    actmem_bankset_scheduler #(.READ_LATENCY(1)) u0 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if0));
    actmem_bankset_scheduler #(.READ_LATENCY(3)) u3 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if3));

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_addrs(input bit scramble);
        for (int b = 0; b < 24; b++) begin
            if0.read_addr_i[b*12 +: 12]  = scramble ? 12'hFFF : 12'h100 + 12'(b);
            if0.write_addr_i[b*12 +: 12] = 12'h200 + 12'(b);
        end
    endtask

    task automatic clr();
        if0.read_req_i  = '0;
        if0.write_req_i = '0;
        if0.read_set_i  = '0;
        if0.write_set_i = '0;
    endtask

    initial begin
        if3.read_req_i   = '0;
        if3.read_set_i   = '0;
        if3.read_addr_i  = '0;
        if3.write_req_i  = '0;
        if3.write_set_i  = '0;
        if3.write_addr_i = '0;
        set_addrs(0);
        if0.read_req_i  = '1;
        if0.read_set_i  = 2'd0;
        if0.write_req_i = '1;
        if0.write_set_i = 2'd1;
        #2;
        check("rst_ready", if0.read_ready_o, 0);
        check("rst_rd_en", if0.set_read_en_o, 0);
        check("rst_wr_en", if0.set_write_en_o, 0);
        check("rst_rvalid", if0.rvalid_o, 0);
        check("rst_rset", if0.rset_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        clr();
        #1;
        check("post_rst_ready", if0.read_ready_o, 1);

        // Read set 0 and write set 1, all banks.
        if0.read_req_i  = '1;
        if0.read_set_i  = 2'd0;
        if0.write_req_i = '1;
        if0.write_set_i = 2'd1;
        #1;
        check("rw_rd_en", if0.set_read_en_o, 72'h000000_000000_FFFFFF);
        check("rw_wr_en", if0.set_write_en_o, 72'h000000_FFFFFF_000000);
        check("rw_coll", if0.rw_collision_o, 0);
        check("rw_addr_s0b0", if0.set_addr_o[0 +: 12], 12'h100);
        check("rw_addr_s1b0", if0.set_addr_o[24*12 +: 12], 12'h200);
        check("rw_addr_s2b0", if0.set_addr_o[48*12 +: 12], 0);
        tick();
        clr();
        check("rw_rvalid", if0.rvalid_o, 24'hFFFFFF);
        check("rw_rset", if0.rset_o, 0);
        tick();
        check("rw_rvalid_gone", if0.rvalid_o, 0);

        // Read set 2 banks 0..3 against a write to set 2 bank 2.
        if0.read_req_i  = 24'hF;
        if0.read_set_i  = 2'd2;
        if0.write_req_i = 24'h4;
        if0.write_set_i = 2'd2;
        #1;
        check("c_rd_en", if0.set_read_en_o, {24'hB, 48'h0});
        check("c_wr_en", if0.set_write_en_o, {24'h4, 48'h0});
        check("c_coll", if0.rw_collision_o, 24'h4);
        check("c_addr_b2", if0.set_addr_o[(48+2)*12 +: 12], 12'h202);
        check("c_addr_b0", if0.set_addr_o[48*12 +: 12], 12'h100);
        tick();
        clr();
        set_addrs(1);
        #1;
        check("c1_ready", if0.read_ready_o, R ? 0 : 1);
        check("c1_rvalid", if0.rvalid_o, 24'hB);
        check("c1_rset", if0.rset_o, 2);
        check("c1_rd_en", if0.set_read_en_o, R ? {24'h4, 48'h0} : 72'h0);
        check("c1_addr_b2", if0.set_addr_o[(48+2)*12 +: 12], R ? 12'h102 : 12'h0);
        check("c1_coll", if0.rw_collision_o, 0);
        tick();
        set_addrs(0);
        check("c2_rvalid", if0.rvalid_o, R ? 24'h4 : 24'h0);
        check("c2_rset", if0.rset_o, 2);
        check("c2_ready", if0.read_ready_o, 1);

        // Bank 5 on set 1 keeps losing to a write held for three cycles.
        if0.read_req_i  = 24'h20;
        if0.read_set_i  = 2'd1;
        if0.write_req_i = 24'h20;
        if0.write_set_i = 2'd1;
        #1;
        check("h_a_coll", if0.rw_collision_o, 24'h20);
        check("h_a_rd_en", if0.set_read_en_o, 0);
        check("h_a_wr_en", if0.set_write_en_o, {24'h0, 24'h20, 24'h0});
        tick();
        if0.read_req_i = '0;
        if0.read_set_i = '0;
        set_addrs(1);
        #1;
        check("h_b_coll", if0.rw_collision_o, R ? 24'h20 : 24'h0);
        check("h_b_ready", if0.read_ready_o, R ? 0 : 1);
        check("h_b_rvalid", if0.rvalid_o, 0);
        tick();
        check("h_c_coll", if0.rw_collision_o, R ? 24'h20 : 24'h0);
        check("h_c_rd_en", if0.set_read_en_o, 0);
        tick();
        if0.write_req_i = '0;
        #1;
        check("h_d_rd_en", if0.set_read_en_o, R ? {24'h0, 24'h20, 24'h0} : 72'h0);
        check("h_d_addr", if0.set_addr_o[(24+5)*12 +: 12], R ? 12'h105 : 12'h0);
        check("h_d_ready", if0.read_ready_o, R ? 0 : 1);
        check("h_d_coll", if0.rw_collision_o, 0);
        tick();
        set_addrs(0);
        check("h_e_rvalid", if0.rvalid_o, R ? 24'h20 : 24'h0);
        check("h_e_rset", if0.rset_o, R ? 1 : 2);
        check("h_e_ready", if0.read_ready_o, 1);

        // Out-of-range set selects are no requests.
        if0.read_req_i  = '1;
        if0.read_set_i  = 2'd3;
        if0.write_req_i = '1;
        if0.write_set_i = 2'd3;
        #1;
        check("oor_rd_en", if0.set_read_en_o, 0);
        check("oor_wr_en", if0.set_write_en_o, 0);
        check("oor_coll", if0.rw_collision_o, 0);
        tick();
        clr();
        check("oor_rvalid", if0.rvalid_o, 0);
        check("oor_ready", if0.read_ready_o, 1);

        // Reset while a replay is pending.
        if0.read_req_i  = 24'h1;
        if0.write_req_i = 24'h1;
        #1;
        check("r_coll", if0.rw_collision_o, 24'h1);
        tick();
        clr();
        #1;
        check("r_ready_pre", if0.read_ready_o, R ? 0 : 1);
        rst_ni = 1'b0;
        #1;
        check("r_ready", if0.read_ready_o, 0);
        check("r_rd_en", if0.set_read_en_o, 0);
        check("r_rvalid", if0.rvalid_o, 0);
        check("r_rset", if0.rset_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        check("r_rel_ready", if0.read_ready_o, 1);
        check("r_rel_rd_en", if0.set_read_en_o, 0);
        tick();
        check("r_rel_rvalid1", if0.rvalid_o, 0);
        tick();
        check("r_rel_rvalid2", if0.rvalid_o, 0);

        // READ_LATENCY=3: set 1 then set 0 back-to-back.
        if3.read_req_i = 24'h1;
        if3.read_set_i = 2'd1;
        tick();
        if3.read_set_i = 2'd0;
        #1;
        check("l3_t1_rvalid", if3.rvalid_o, 0);
        tick();
        if3.read_req_i = '0;
        #1;
        check("l3_t2_rvalid", if3.rvalid_o, 0);
        tick();
        check("l3_t3_rvalid", if3.rvalid_o, 24'h1);
        check("l3_t3_rset", if3.rset_o, 1);
        tick();
        check("l3_t4_rvalid", if3.rvalid_o, 24'h1);
        check("l3_t4_rset", if3.rset_o, 0);
        tick();
        check("l3_t5_rvalid", if3.rvalid_o, 0);
        check("l3_t5_rset", if3.rset_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/actmem_bankset_scheduler.md
ACTMEM_BANKSET_SCHEDULER -- requirements
Module: actmem_bankset_scheduler

Interface
REQ-001 The block SHALL have parameter NUMBANKS, default 24, banks per bank set.
REQ-002 The block SHALL have parameter NUMBANKSETS, default 3, bank sets; BSW = NUMBANKSETS>1 ? clog2(NUMBANKSETS) : 1.
REQ-003 The block SHALL have parameter ADDRWIDTH, default 12, per-bank word address width.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, legal 1..4, SRAM read latency in cycles.
REQ-005 The block SHALL have these ports:
  clk_i  in  1  clock
  rst_ni  in  1  reset, asynchronous, active-low
  read_req_i  in  NUMBANKS  per-bank read request
  read_set_i  in  BSW  target set of read
  read_addr_i  in  NUMBANKS*ADDRWIDTH  per-bank read address
  write_req_i  in  NUMBANKS  per-bank write request
  write_set_i  in  BSW  target set of write
  write_addr_i  in  NUMBANKS*ADDRWIDTH  per-bank write address
  read_ready_o  out  1  new read request accepted this cycle
  set_read_en_o  out  NUMBANKSETS*NUMBANKS  per-set, per-bank SRAM read enable
  set_write_en_o  out  NUMBANKSETS*NUMBANKS  per-set, per-bank SRAM write enable
  set_addr_o  out  NUMBANKSETS*NUMBANKS*ADDRWIDTH  per-set, per-bank shared SRAM address
  rvalid_o  out  NUMBANKS  per-bank read data valid at SRAM output
  rset_o  out  BSW  set to mux onto activation output while rvalid_o is nonzero
  rw_collision_o  out  NUMBANKS  banks whose read lost to a write this cycle

Function
REQ-006 Writes SHALL always issue combinationally: set_write_en_o[write_set_i] = write_req_i, all other sets 0.
REQ-007 A collision SHALL be bank b with read and write both requested on the same set in the same cycle; the write wins.
REQ-008 Per set/bank, set_addr_o SHALL be the write address when write-enabled, else the issued read address, else 0.
REQ-009 Reads on non-colliding banks SHALL issue in the request cycle; set_read_en_o[read_set_i] = read_req_i & ~collision.
REQ-010 FSM states SHALL be IDLE and REPLAY; reset state IDLE.
REQ-011 IDLE: read_ready_o=1; on a collision, the collided bank mask, their addresses and read_set_i SHALL be captured and the FSM SHALL go to REPLAY.
REQ-012 REPLAY: read_ready_o=0, read_*_i ignored; the captured banks SHALL issue on the captured set with the captured addresses; banks colliding again with a current write SHALL stay captured; FSM SHALL return to IDLE once the mask is empty.
REQ-013 Each issued read SHALL assert rvalid_o[b] exactly READ_LATENCY cycles after issue, with rset_o equal to the issuing set in that cycle; rset_o SHALL hold its last value when rvalid_o=0.
REQ-014 rw_collision_o SHALL flag collided banks in the cycle of the collision only, including repeat collisions during REPLAY.
REQ-015 Read and write to the same set on disjoint banks SHALL both issue in the same cycle without collision.
REQ-016 Out-of-range read_set_i/write_set_i (>= NUMBANKSETS) SHALL be treated as no request.

Reset
REQ-017 Asynchronous reset SHALL force FSM=IDLE, replay mask/addresses/set=0, latency pipeline valid bits=0, rset_o=0, rvalid_o=0.
REQ-018 Reset during REPLAY SHALL discard pending replay reads; no rvalid_o for them after reset release.
REQ-019 During reset, all enables SHALL be 0 and read_ready_o SHALL be 0.

Configuration
REQ-020 With ACTMEM_READ_REPLAY_EN defined, collided reads SHALL be replayed as REQ-011..REQ-012.
REQ-021 Without ACTMEM_READ_REPLAY_EN, the FSM SHALL stay IDLE, read_ready_o SHALL be 1 outside reset, and collided reads SHALL be dropped (flagged on rw_collision_o only, no rvalid_o).

Verification
REQ-022 Read set 0 all banks and write set 1 all banks in the same cycle -> both issue, rvalid_o all-ones 1 cycle later (READ_LATENCY=1), rset_o=0, no collision.
REQ-023 Read set 2 banks 0..3 and write set 2 bank 2 in the same cycle -> banks 0,1,3 issue; rw_collision_o=bank 2; read_ready_o=0 next cycle; bank 2 is re-read with the captured address; rvalid_o bank 2 one cycle after the others.
REQ-024 Replay bank 5 with a write to set/bank 5 held for 3 cycles -> rw_collision_o[5] set in each of those cycles, read issues in 4th cycle, FSM then IDLE.
REQ-025 READ_LATENCY=3, reads on set 1 then set 0 back-to-back -> rvalid_o at cycles +3/+4 with rset_o=1 then 0.
REQ-026 Assert rst_ni low while in REPLAY -> outputs at reset values; after release, no stray rvalid_o and read_ready_o=1.
REQ-027 Build without ACTMEM_READ_REPLAY_EN, repeat REQ-023 -> bank 2 dropped, read_ready_o stays 1, no rvalid_o for bank 2.
